// File: rtl/data_generator.sv
// data_generator: valid/ready stimulus source. It produces a programmable
// number of words (0 = continuous) from one of four patterns. Each accepted
// word can be followed by a programmable gap. Backpressure is honoured and
// a stop request is applied at the next word boundary.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_start       start pulse, sampled only when idle
//   i_stop        stop request, takes effect at the next word boundary
//   i_mode        pattern: 0 increment, 1 LFSR, 2 constant, 3 walking rotate
//   i_seed        first word of the sequence
//   i_nb_data     number of words to send, 0 = continuous
//   i_gap         idle cycles after each accepted word
//   i_ready       downstream ready
//   o_data        data word
//   o_data_valid  data valid
//   o_busy        sequence in progress
//   o_done        one-cycle end-of-sequence pulse
//   o_sent_cnt    handshakes completed since the last start
module data_generator #(
  parameter int unsigned G_DATA_WIDTH = 32,
  parameter int unsigned G_CNT_WIDTH  = 16,
  parameter int unsigned G_GAP_WIDTH  = 8,
  parameter logic [31:0] G_LFSR_POLY  = 32'h80200003
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [1:0]              i_mode,
  input  logic [G_DATA_WIDTH-1:0] i_seed,
  input  logic [G_CNT_WIDTH-1:0]  i_nb_data,
  input  logic [G_GAP_WIDTH-1:0]  i_gap,
  input  logic                    i_ready,
  output logic [G_DATA_WIDTH-1:0] o_data,
  output logic                    o_data_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [G_CNT_WIDTH-1:0]  o_sent_cnt
);

  localparam int unsigned DW = G_DATA_WIDTH;
  localparam int unsigned CW = G_CNT_WIDTH;
  localparam int unsigned GW = G_GAP_WIDTH;
  localparam logic [DW-1:0] POLY = G_LFSR_POLY[DW-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] nb_q, nb_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          stop_pend_q, stop_pend_d;

  logic          last_word;
  logic          stop_now;
  logic          end_seq;
  logic          gap_expire;
  logic [DW-1:0] first_word;

  // Pattern step applied on each handshake
  function automatic logic [DW-1:0] next_word(input logic [1:0] mode,
                                               input logic [DW-1:0] cur);
    logic [DW-1:0] nxt;
    case (mode)
      2'd0:    nxt = cur + DW'(1);
      2'd1:    nxt = (cur >> 1) ^ (cur[0] ? POLY : '0);
      2'd2:    nxt = cur;
      default: nxt = {cur[DW-2:0], cur[DW-1]};
    endcase
    return nxt;
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed starts at 1
  assign first_word = ((i_mode == 2'd1) && (i_seed == '0)) ? DW'(1) : i_seed;
  assign last_word  = (nb_q != '0) && ((cnt_q + CW'(1)) == nb_q);
  assign stop_now   = i_stop | stop_pend_q;
  assign end_seq    = last_word | stop_now;
  assign gap_expire = (gap_cnt_q <= GW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_SEND;
      S_SEND: begin
        if (i_ready) begin
          if (end_seq)             state_d = S_IDLE;
          else if (gap_q != '0)    state_d = S_GAP;
        end
      end
      S_GAP:   if (gap_expire) state_d = stop_now ? S_IDLE : S_SEND;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values (registered below)
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    nb_d        = nb_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mode_d      = i_mode;
          nb_d        = i_nb_data;
          gap_d       = i_gap;
          data_d      = first_word;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
        end
      end
      S_SEND: begin
        if (i_ready) begin
          cnt_d  = cnt_q + CW'(1);
          data_d = next_word(mode_q, data_q);
          if (end_seq) begin
            done_d      = 1'b1;
            busy_d      = 1'b0;
            valid_d     = 1'b0;
            stop_pend_d = 1'b0;
          end else if (gap_q != '0) begin
            valid_d   = 1'b0;
            gap_cnt_d = gap_q;
          end
        end else if (i_stop) begin
          // The presented word stays up; the stop waits for its handshake
          stop_pend_d = 1'b1;
        end
      end
      S_GAP: begin
        if (i_stop) stop_pend_d = 1'b1;
        if (gap_expire) begin
          if (stop_now) begin
            done_d      = 1'b1;
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            valid_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= '0;
      nb_q        <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      nb_q        <= nb_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_sent_cnt   = cnt_q;

endmodule
